// File: rtl/mult_arbiter_pkg.sv
// mult_pkg: shared definitions for the multiplier arbiter.
//   - default operand width and requester count
//   - request/response record types at the default widths
//   - rr_pick: round-robin one-hot grant selection
package mult_pkg;

    localparam int N_DEF    = 16;
    localparam int NREQ_DEF = 4;
    // rr_pick works on a fixed maximum width so it can live in the package;
    // callers zero-extend their vectors and slice the result.
    localparam int NREQ_MAX = 16;
    localparam int PTR_W    = 4;

    typedef struct packed {
        logic [N_DEF-1:0] a;
        logic [N_DEF-1:0] b;
    } mult_req_t;

    typedef struct packed {
        logic [$clog2(NREQ_DEF)-1:0] id;
        logic [2*N_DEF-1:0]          result;
        logic                        ov;
    } mult_rsp_t;

    // First set bit of valid searching ptr, ptr+1, ... wrapping at nreq.
    // ptr must be below nreq. Returns all zeros when nothing is valid.
    function automatic logic [NREQ_MAX-1:0] rr_pick(
        input logic [NREQ_MAX-1:0] valid,
        input logic [PTR_W-1:0]    ptr,
        input int                  nreq
    );
        logic [NREQ_MAX-1:0] g;
        logic                found;
        logic [PTR_W:0]      sum;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            // ptr < nreq and k < nreq, so one subtraction completes the wrap
            sum = {1'b0, ptr} + 5'(k);
            if (sum >= 5'(nreq)) begin
                sum = sum - 5'(nreq);
            end
            if ((k < nreq) && !found && valid[sum[PTR_W-1:0]]) begin
                g[sum[PTR_W-1:0]] = 1'b1;
                found             = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mult_arbiter_op_mult.sv
// op_mult: combinational N x N -> 2N multiplier.
//   a, b    in   N   operands (two's complement when SIGNED != 0)
//   result  out  2N  product, clamped when SATURATE != 0 and ov is set
//   ov      out  1   signed mode only: product does not fit in 2N-1 bits,
//                    i.e. the two top bits of the full product differ. For
//                    fractional (Q) operands this is the single case
//                    most-negative * most-negative.
module op_mult #(
    parameter int N        = 16,
    parameter int SATURATE = 1,
    parameter int SIGNED   = 1
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] result,
    output logic           ov
);
    logic [2*N-1:0] a_ext;
    logic [2*N-1:0] b_ext;
    logic [2*N-1:0] prod;
    logic           raw_ov;

    // The low 2N bits of a 2N x 2N product of extended operands are the
    // exact N x N product in either signedness.
    if (SIGNED != 0) begin : g_signed
        assign a_ext  = {{N{a[N-1]}}, a};
        assign b_ext  = {{N{b[N-1]}}, b};
        assign raw_ov = prod[2*N-1] ^ prod[2*N-2];
    end else begin : g_unsigned
        assign a_ext  = {{N{1'b0}}, a};
        assign b_ext  = {{N{1'b0}}, b};
        assign raw_ov = 1'b0;
    end

    assign prod = a_ext * b_ext;
    assign ov   = raw_ov;

    if (SATURATE != 0) begin : g_sat
        // Clamp toward the sign of the true product (top bit of prod).
        assign result = !raw_ov ? prod :
                        (prod[2*N-1] ? {1'b1, {(2*N-1){1'b0}}}
                                     : {1'b0, {(2*N-1){1'b1}}});
    end else begin : g_wrap
        assign result = prod;
    end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one op_mult between NREQ requesters.
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-requester request handshake (ready one-hot or 0)
//   req_a, req_b      packed operands, slice i belongs to requester i
//   rsp_valid/ready   shared response handshake
//   rsp_id            requester index of the result
//   rsp_result/ov     product and overflow flag from op_mult
//   ov_count          saturating count of delivered responses with ov set
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. Requesters hold valid and operands until accepted; the block
// holds rsp_* while rsp_valid & !rsp_ready. req_ready depends on req_valid
// combinationally; no path runs from any ready to a valid.
//
// Pipeline: S1 (issue register) -> op_mult -> S2 (rsp_* register).
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int NREQ     = NREQ_DEF,
    parameter int SATURATE = 1,
    parameter int SIGNED   = 1,
    parameter int IDW      = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*N-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [2*N-1:0]      rsp_result,
    output logic                rsp_ov,
    output logic [15:0]         ov_count
);
    logic                s1_valid;
    logic [IDW-1:0]      s1_id;
    logic [N-1:0]        s1_a;
    logic [N-1:0]        s1_b;
    logic [IDW-1:0]      rr;

    logic                s2_free;
    logic                s1_free;
    logic                issue;
    logic [NREQ_MAX-1:0] valid_ext;
    logic [PTR_W-1:0]    rr_ext;
    logic [NREQ_MAX-1:0] pick;
    logic [NREQ-1:0]     grant;
    logic [IDW-1:0]      grant_id;
    logic [IDW-1:0]      rr_next;
    logic [N-1:0]        grant_a;
    logic [N-1:0]        grant_b;
    logic [2*N-1:0]      mult_result;
    logic                mult_ov;

    assign s2_free = !rsp_valid || rsp_ready;
    assign s1_free = !s1_valid || s2_free;
    assign issue   = s1_free && (|req_valid);

    always_comb begin
        valid_ext               = '0;
        valid_ext[NREQ-1:0]     = req_valid;
        rr_ext                  = '0;
        rr_ext[IDW-1:0]         = rr;
        pick                    = rr_pick(valid_ext, rr_ext, NREQ);
        grant                   = pick[NREQ-1:0];
        grant_id                = '0;
        for (int i = 0; i < NREQ_MAX; i++) begin
            if (pick[i]) begin
                grant_id = IDW'(i);
            end
        end
    end

    assign rr_next = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);
    assign grant_a = req_a[int'(grant_id)*N +: N];
    assign grant_b = req_b[int'(grant_id)*N +: N];

    // rst_n gates ready so nothing looks accepted while the flops are held.
    assign req_ready = grant & {NREQ{s1_free && rst_n}};

    // S1 issue register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            rr       <= '0;
        end else if (s1_free) begin
            s1_valid <= issue;
            if (issue) begin
                s1_id <= grant_id;
                s1_a  <= grant_a;
                s1_b  <= grant_b;
                rr    <= rr_next;
            end
        end
    end

    op_mult #(
        .N        (N),
        .SATURATE (SATURATE),
        .SIGNED   (SIGNED)
    ) u_op_mult (
        .a      (s1_a),
        .b      (s1_b),
        .result (mult_result),
        .ov     (mult_ov)
    );

    // S2 output register: loads whenever it is empty or being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_ov     <= 1'b0;
        end else if (s2_free) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_id     <= s1_id;
                rsp_result <= mult_result;
                rsp_ov     <= mult_ov;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_count <= '0;
        end else if (rsp_valid && rsp_ready && rsp_ov && (ov_count != 16'hFFFF)) begin
            ov_count <= ov_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;
    import mult_pkg::*;

    localparam int N     = 16;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int EXP_W = IDW + 1 + 2 * N;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a = '0;
    logic [NREQ*N-1:0] req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [2*N-1:0]    rsp_result;
    logic              rsp_ov;
    logic [15:0]       ov_count;

    mult_arbiter #(.N(N), .NREQ(NREQ), .SATURATE(1), .SIGNED(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_ov     (rsp_ov),
        .ov_count   (ov_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: signed Q-style multiply, overflow when the product leaves
    // the 2N-1 bit signed range, saturating.
    function automatic logic [32:0] ref_mult(input logic [15:0] a, input logic [15:0] b);
        longint pa, pb, p;
        logic [31:0] r;
        logic ov;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        p  = pa * pb;
        ov = (p > 64'sd1073741823) || (p < -64'sd1073741824);
        if (ov) r = (p > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        else    r = p[31:0];
        return {ov, r};
    endfunction

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    // scoreboard: {id, ov, result} in issue order
    logic [EXP_W-1:0] exp_q[$];
    logic [NREQ-1:0]  acc_last = '0;
    int               acc_total = 0;
    int               rsp_count = 0;
    logic [15:0]      ov_exp = '0;
    logic             order_check = 1'b0;
    int               order_exp = 0;
    int               waits[NREQ];
    logic             prev_stall = 1'b0;
    logic [EXP_W-1:0] prev_rsp = '0;

    always @(negedge clk) begin : mon
        logic [EXP_W-1:0] e;
        logic [NREQ-1:0]  acc;
        int               g;
        if (!rst_n) begin
            acc_last   = '0;
            ov_exp     = '0;
            prev_stall = 1'b0;
            for (int i = 0; i < NREQ; i++) waits[i] = 0;
        end else begin
            check("ready_onehot", 64'($countones(req_ready) <= 1), 1);
            if (prev_stall) begin
                check("stall_stable", {rsp_valid, rsp_id, rsp_ov, rsp_result}, {1'b1, prev_rsp});
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_rsp   = {rsp_id, rsp_ov, rsp_result};

            if (rsp_valid && rsp_ready) begin
                check("ov_count", ov_count, ov_exp);
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", rsp_id, e[EXP_W-1 -: IDW]);
                    check("rsp_ov", rsp_ov, e[2*N]);
                    check("rsp_result", rsp_result, e[2*N-1:0]);
                    if (e[2*N] && ov_exp != 16'hFFFF) ov_exp = ov_exp + 16'd1;
                end
                rsp_count++;
            end

            acc      = req_valid & req_ready;
            acc_last = acc;
            if (|acc) begin
                g = 0;
                for (int i = 0; i < NREQ; i++) if (acc[i]) g = i;
                exp_q.push_back({IDW'(g), ref_mult(req_a[g*N +: N], req_b[g*N +: N])});
                acc_total++;
                if (order_check) begin
                    check("grant_order", g, order_exp);
                    order_exp = (order_exp + 1) % NREQ;
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i] && !acc[i]) begin
                        waits[i]++;
                        check("fair_wait", 64'(waits[i] < NREQ), 1);
                    end else begin
                        waits[i] = 0;
                    end
                end
            end
        end
    end

    // driver: one cycle, holding unaccepted requests and their operands
    task automatic step(input logic [NREQ-1:0] want, input logic rdy);
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || acc_last[i]) begin
                req_valid[i]       = want[i];
                req_a[i*N +: N]    = rand_op();
                req_b[i*N +: N]    = rand_op();
            end
        end
        rsp_ready = rdy;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (exp_q.size() != 0 || req_valid != '0); k++) step('0, 1'b1);
        step('0, 1'b1);
        check("drain_empty", exp_q.size(), 0);
        check("drain_idle", req_valid, 0);
    endtask

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] res;
        logic        ov;
    } vec_t;

    task automatic send_vec(input vec_t v);
        logic got;
        @(posedge clk);
        #1;
        req_valid          = '0;
        req_valid[v.id]    = 1'b1;
        req_a[v.id*N +: N] = v.a;
        req_b[v.id*N +: N] = v.b;
        rsp_ready          = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (req_ready[v.id]) got = 1'b1;
        end
        check("vec_accept", got, 1);
        @(posedge clk);
        #1;
        req_valid = '0;
        if (got) begin
            @(negedge clk);
            check("vec_lat_early", rsp_valid, 0);
            @(negedge clk);
            check("vec_rsp_valid", rsp_valid, 1);
            check("vec_rsp_id", rsp_id, v.id);
            check("vec_rsp_result", rsp_result, v.res);
            check("vec_rsp_ov", rsp_ov, v.ov);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t        tbl[8];
        logic        got;
        logic [15:0] ov_before;
        int          base_acc, base_rsp;

        tbl[0] = '{2, 16'd3,    16'hFFFB, 32'hFFFF_FFF1, 1'b0};
        tbl[1] = '{0, 16'h8000, 16'h8000, 32'h7FFF_FFFF, 1'b1};
        tbl[2] = '{1, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001, 1'b0};
        tbl[3] = '{3, 16'h8000, 16'h7FFF, 32'hC000_8000, 1'b0};
        tbl[4] = '{0, 16'hFFFF, 16'hFFFF, 32'h0000_0001, 1'b0};
        tbl[5] = '{1, 16'h0000, 16'h1234, 32'h0000_0000, 1'b0};
        tbl[6] = '{3, 16'h8000, 16'h0001, 32'hFFFF_8000, 1'b0};
        tbl[7] = '{2, 16'h7FFF, 16'h8000, 32'hC000_8000, 1'b0};

        // reset state, with requests pending to show ready stays low
        req_valid = '1;
        #23;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_ov_count", ov_count, 0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // table-driven single transactions
        for (int i = 0; i < 8; i++) send_vec(tbl[i]);
        drain();

        // overflow counter moves only on the transfer edge
        @(posedge clk);
        #1;
        rsp_ready        = 1'b0;
        req_valid        = 4'b0010;
        req_a[1*N +: N]  = 16'h8000;
        req_b[1*N +: N]  = 16'h8000;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (req_ready[1]) got = 1'b1;
        end
        check("ov_accept", got, 1);
        @(posedge clk);
        #1;
        req_valid = '0;
        ov_before = ov_exp;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        check("ov_rsp_seen", got, 1);
        check("ov_flag", rsp_ov, 1);
        check("ov_sat_result", rsp_result, 32'h7FFF_FFFF);
        repeat (3) @(negedge clk);
        check("ov_hold_count", ov_count, ov_before);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("ov_pre_edge", ov_count, ov_before);
        @(posedge clk);
        #1;
        check("ov_post_edge", ov_count, ov_before + 16'd1);
        drain();

        // backpressure: all valid, sink stalled for 5 cycles
        base_acc = acc_total;
        base_rsp = rsp_count;
        for (int c = 0; c < 5; c++) begin
            step('1, 1'b0);
            @(negedge clk);
            if (c >= 2) check("bp_ready_low", req_ready, 0);
        end
        check("bp_accepted", acc_total - base_acc, 2);
        drain();
        check("bp_delivered", rsp_count - base_rsp, acc_total - base_acc);

        // constrained random traffic
        for (int c = 0; c < 400; c++) begin
            step(NREQ'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
        end
        drain();

        // reset with both stages full
        for (int c = 0; c < 3; c++) step('1, 1'b0);
        @(negedge clk);
        check("mid_s2_full", rsp_valid, 1);
        check("mid_s1_full", req_ready, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_id", rsp_id, 0);
        check("mid_rst_rsp_result", rsp_result, 0);
        check("mid_rst_rsp_ov", rsp_ov, 0);
        check("mid_rst_ov_count", ov_count, 0);
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        rsp_ready   = 1'b1;
        order_exp   = 0;
        order_check = 1'b1;
        @(negedge clk);
        check("post_rst_first_grant", req_ready, 4'b0001);
        check("post_rst_no_stale", rsp_valid, 0);

        // continuous contention: round-robin order, one response per cycle
        for (int c = 0; c < 12; c++) begin
            step('1, 1'b1);
            @(negedge clk);
            if (c >= 1) check("throughput", rsp_valid, 1);
        end
        order_check = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
